saber_ignition_ctrl: RTL and testbench



---
 rtl/saber_ignition_ctrl_pkg.sv | 14 +
 rtl/saber_ignition_ctrl_if.sv | 24 ++
 rtl/saber_ramp_tick.sv | 26 ++
 rtl/saber_ignition_ctrl.sv | 114 +++++++++++
 tb/tb_saber_ignition_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/saber_ignition_ctrl_pkg.sv
// Shared types and constants for the lightsaber ignition sequencer.
package saber_ignition_ctrl_pkg;
   localparam int   LEN_W        = 8;
   localparam logic PWR_RECHARGE = 1'b0;
   localparam logic PWR_DRAIN    = 1'b1;

   typedef enum logic [2:0] {
      OFF     = 3'd0,
      IGNITE  = 3'd1,
      ON      = 3'd2,
      RETRACT = 3'd3,
      LOCKOUT = 3'd4
   } state_t;
endpackage

// File: rtl/saber_ignition_ctrl_if.sv
// User/power inputs and blade control outputs of the ignition sequencer.
interface saber_ignition_ctrl_if;
   logic       btn;
   logic [1:0] tgt_in;
   logic [5:0] tgt_dec;
   logic       power_warn;
   logic [7:0] power_level;
   logic       saber_on;
   logic [1:0] len_in;
   logic [5:0] len_dec;
   logic       power_mode;
   logic       busy;
   logic       locked;

   modport master (
      output btn, tgt_in, tgt_dec, power_warn, power_level,
      input  saber_on, len_in, len_dec, power_mode, busy, locked
   );

   modport slave (
      input  btn, tgt_in, tgt_dec, power_warn, power_level,
      output saber_on, len_in, len_dec, power_mode, busy, locked
   );
endinterface

// File: rtl/saber_ramp_tick.sv
// Ramp prescaler: counts 0..RAMP_DIV-1 while enabled, pulses tick on the last count.
module saber_ramp_tick #(
   parameter int RAMP_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);
   localparam int            CW   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(RAMP_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= tick ? '0 : cnt + 1'b1;
   end
endmodule

// File: rtl/saber_ignition_ctrl.sv
// Ignite/retract sequencer: ramps blade length, drives enable and power mode,
// and forces retract plus lockout on a power warning.
module saber_ignition_ctrl
   import saber_ignition_ctrl_pkg::*;
#(
   parameter int RAMP_DIV    = 4,
   parameter int STEP        = 8,
   parameter int RESTART_LVL = 64
) (
   input logic                 clk,
   input logic                 rst,
   saber_ignition_ctrl_if.slave bus
);
   state_t           state, state_nxt;
   logic [LEN_W-1:0] len, len_nxt, tgt, up_len, dn_len;
   logic [LEN_W:0]   sum;
   logic             warn_flag, warn_flag_nxt;
   logic             tick, ramping, active_nxt;

   assign tgt     = {bus.tgt_in, bus.tgt_dec};
   assign ramping = (state == IGNITE) || (state == RETRACT);

   // 9-bit sum so a step near full scale clamps to target instead of wrapping
   assign sum    = {1'b0, len} + (LEN_W+1)'(STEP);
   assign up_len = (sum > {1'b0, tgt}) ? tgt : sum[LEN_W-1:0];
   assign dn_len = ({1'b0, len} > (LEN_W+1)'(STEP)) ? len - LEN_W'(STEP) : '0;

   saber_ramp_tick #(.RAMP_DIV(RAMP_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (ramping),
      .clr  (state_nxt != state),
      .tick (tick)
   );

   always_comb begin
      state_nxt     = state;
      len_nxt       = len;
      warn_flag_nxt = warn_flag;
      case (state)
         OFF: begin
            len_nxt = '0;
            if (bus.btn)
               state_nxt = bus.power_warn ? LOCKOUT : IGNITE;
         end
         IGNITE: begin
            if (bus.power_warn) begin
               state_nxt     = RETRACT;
               warn_flag_nxt = 1'b1;
            end else if (!bus.btn) begin
               state_nxt = RETRACT;
            end else if (tick) begin
               len_nxt = up_len;
               if (up_len == tgt)
                  state_nxt = ON;
            end
         end
         ON: begin
            len_nxt = tgt;
            if (bus.power_warn) begin
               state_nxt     = RETRACT;
               warn_flag_nxt = 1'b1;
            end else if (!bus.btn) begin
               state_nxt = RETRACT;
            end
         end
         RETRACT: begin
            if (bus.btn && !warn_flag) begin
               state_nxt = IGNITE;
            end else if (tick) begin
               len_nxt = dn_len;
               if (dn_len == '0)
                  state_nxt = warn_flag ? LOCKOUT : OFF;
            end
         end
         LOCKOUT: begin
            len_nxt = '0;
            if (bus.power_level >= 8'(RESTART_LVL) && !bus.power_warn && !bus.btn)
               state_nxt = OFF;
         end
         default: begin
            state_nxt = OFF;
            len_nxt   = '0;
         end
      endcase
      if (state_nxt == OFF)
         warn_flag_nxt = 1'b0;
   end

   assign active_nxt = (state_nxt == IGNITE) || (state_nxt == ON) || (state_nxt == RETRACT);

   // Status outputs are registered from the next state so they align with state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= OFF;
         len            <= '0;
         warn_flag      <= 1'b0;
         bus.saber_on   <= 1'b0;
         bus.power_mode <= PWR_RECHARGE;
         bus.busy       <= 1'b0;
         bus.locked     <= 1'b0;
      end else begin
         state          <= state_nxt;
         len            <= len_nxt;
         warn_flag      <= warn_flag_nxt;
         bus.saber_on   <= active_nxt;
         bus.power_mode <= active_nxt ? PWR_DRAIN : PWR_RECHARGE;
         bus.busy       <= (state_nxt == IGNITE) || (state_nxt == RETRACT);
         bus.locked     <= (state_nxt == LOCKOUT);
      end
   end

   assign {bus.len_in, bus.len_dec} = len;
endmodule

// File: tb/tb_saber_ignition_ctrl.sv
// Self-checking bench for saber_ignition_ctrl against a behavioural blade model.
module tb_saber_ignition_ctrl;
   localparam int RAMP_DIV = 4, STEP = 8, RESTART_LVL = 64;
   localparam int P_OFF = 0, P_UP = 1, P_ON = 2, P_DOWN = 3, P_LOCK = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   saber_ignition_ctrl_if bus ();

   saber_ignition_ctrl #(.RAMP_DIV(RAMP_DIV), .STEP(STEP), .RESTART_LVL(RESTART_LVL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0, bad = 0;

   // Model: phase, blade length, cycles spent in the current ramp phase, warn latch
   int m_ph, m_len, m_age;
   bit m_warn;

   function automatic logic [11:0] act();
      return {bus.saber_on, bus.power_mode, bus.busy, bus.locked, bus.len_in, bus.len_dec};
   endfunction

   function automatic logic [11:0] exp_v();
      logic on_w = (m_ph == P_UP) || (m_ph == P_ON) || (m_ph == P_DOWN);
      return {on_w, on_w, (m_ph == P_UP) || (m_ph == P_DOWN), m_ph == P_LOCK, 8'(m_len)};
   endfunction

   task automatic model_reset();
      m_ph = P_OFF; m_len = 0; m_age = 0; m_warn = 0;
   endtask

   task automatic model_step();
      int tgt = int'({bus.tgt_in, bus.tgt_dec});
      int nph = m_ph;
      bit tk  = (m_age % RAMP_DIV) == RAMP_DIV - 1;
      case (m_ph)
         P_OFF: begin
            m_len = 0;
            if (bus.btn) nph = bus.power_warn ? P_LOCK : P_UP;
         end
         P_UP: begin
            if (bus.power_warn) begin nph = P_DOWN; m_warn = 1; end
            else if (!bus.btn) nph = P_DOWN;
            else if (tk) begin
               m_len = (m_len + STEP < tgt) ? m_len + STEP : tgt;
               if (m_len == tgt) nph = P_ON;
            end
         end
         P_ON: begin
            m_len = tgt;
            if (bus.power_warn) begin nph = P_DOWN; m_warn = 1; end
            else if (!bus.btn) nph = P_DOWN;
         end
         P_DOWN: begin
            if (bus.btn && !m_warn) nph = P_UP;
            else if (tk) begin
               m_len = (m_len > STEP) ? m_len - STEP : 0;
               if (m_len == 0) nph = m_warn ? P_LOCK : P_OFF;
            end
         end
         default: begin
            m_len = 0;
            if (int'(bus.power_level) >= RESTART_LVL && !bus.power_warn && !bus.btn) nph = P_OFF;
         end
      endcase
      if (nph != m_ph) m_age = 0;
      else if (m_ph == P_UP || m_ph == P_DOWN) m_age++;
      m_ph = nph;
      if (nph == P_OFF) m_warn = 0;
   endtask

   task automatic tick_clk();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic drive(input bit b, input int tgt, input bit w, input int lvl);
      bus.btn         = b;
      {bus.tgt_in, bus.tgt_dec} = 8'(tgt);
      bus.power_warn  = w;
      bus.power_level = 8'(lvl);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(0, 0, 0, 0);
      repeat (2) @(negedge clk);
      model_reset();
      total++; if (bus.saber_on !== 1'b0) begin bad++; $display("FAIL reset_saber_on: got %b want 0", bus.saber_on); end
      total++; if (bus.power_mode !== 1'b0) begin bad++; $display("FAIL reset_power_mode: got %b want 0", bus.power_mode); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      total++; if (bus.locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b want 0", bus.locked); end
      total++; if ({bus.len_in, bus.len_dec} !== 8'd0) begin bad++; $display("FAIL reset_len: got %0d want 0", {bus.len_in, bus.len_dec}); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_ignite();
      drive(1, 96, 0, 100);
      for (int i = 0; i < 49; i++) begin
         tick_clk();
         total++; if (act() !== exp_v()) begin bad++; $display("FAIL ignite_model cyc %0d: got %h want %h", i, act(), exp_v()); end
         total++; if ({bus.len_in, bus.len_dec} !== 8'(STEP * (i / RAMP_DIV))) begin
            bad++; $display("FAIL ignite_len cyc %0d: got %0d want %0d", i, {bus.len_in, bus.len_dec}, STEP * (i / RAMP_DIV)); end
      end
      total++; if ({bus.saber_on, bus.power_mode, bus.busy} !== 3'b110) begin
         bad++; $display("FAIL ignite_on_flags: got %b want 110", {bus.saber_on, bus.power_mode, bus.busy}); end
   endtask

   task automatic test_retract();
      drive(0, 96, 0, 100);
      for (int i = 0; i < 49; i++) begin
         tick_clk();
         total++; if (act() !== exp_v()) begin bad++; $display("FAIL retract_model cyc %0d: got %h want %h", i, act(), exp_v()); end
         total++; if ({bus.len_in, bus.len_dec} !== 8'(96 - STEP * (i / RAMP_DIV))) begin
            bad++; $display("FAIL retract_len cyc %0d: got %0d want %0d", i, {bus.len_in, bus.len_dec}, 96 - STEP * (i / RAMP_DIV)); end
      end
      total++; if ({bus.saber_on, bus.power_mode, bus.busy} !== 3'b000) begin
         bad++; $display("FAIL retract_off_flags: got %b want 000", {bus.saber_on, bus.power_mode, bus.busy}); end
   endtask

   task automatic test_warn_lockout();
      int k;
      drive(1, 96, 0, 10);
      for (k = 0; k < 200 && m_ph != P_ON; k++) begin
         tick_clk();
         total++; if (act() !== exp_v()) begin bad++; $display("FAIL warn_ign_model: got %h want %h", act(), exp_v()); end
      end
      total++; if (m_ph != P_ON) begin bad++; $display("FAIL warn_ign_timeout: got phase %0d want %0d", m_ph, P_ON); end
      drive(1, 96, 1, 10);
      tick_clk();
      drive(1, 96, 0, 10);
      for (k = 0; k < 200 && m_ph != P_LOCK; k++) begin
         tick_clk();
         total++; if (act() !== exp_v()) begin bad++; $display("FAIL warn_ret_model: got %h want %h", act(), exp_v()); end
      end
      total++; if (bus.locked !== 1'b1) begin bad++; $display("FAIL warn_locked: got %b want 1", bus.locked); end
      drive(1, 96, 0, 64);
      for (k = 0; k < 10; k++) begin
         tick_clk();
         total++; if (bus.locked !== 1'b1 || bus.saber_on !== 1'b0) begin
            bad++; $display("FAIL lock_hold: got locked=%b on=%b want locked=1 on=0", bus.locked, bus.saber_on); end
      end
      drive(0, 96, 0, 64);
      tick_clk();
      total++; if (act() !== exp_v()) begin bad++; $display("FAIL lock_exit_model: got %h want %h", act(), exp_v()); end
      total++; if (bus.locked !== 1'b0) begin bad++; $display("FAIL lock_exit: got %b want 0", bus.locked); end
   endtask

   task automatic test_reverse();
      int k;
      drive(1, 96, 0, 100);
      for (k = 0; k < 200 && m_len != 40; k++) begin
         tick_clk();
         total++; if (act() !== exp_v()) begin bad++; $display("FAIL rev_up_model: got %h want %h", act(), exp_v()); end
      end
      drive(0, 96, 0, 100);
      for (k = 0; k < 200 && m_len != 24; k++) begin
         tick_clk();
         total++; if (act() !== exp_v()) begin bad++; $display("FAIL rev_down_model: got %h want %h", act(), exp_v()); end
      end
      total++; if (bus.busy !== 1'b1 || {bus.len_in, bus.len_dec} !== 8'd24) begin
         bad++; $display("FAIL rev_at24: got busy=%b len=%0d want busy=1 len=24", bus.busy, {bus.len_in, bus.len_dec}); end
      drive(1, 96, 0, 100);
      for (k = 0; k < 200 && m_ph != P_ON; k++) begin
         tick_clk();
         total++; if (act() !== exp_v()) begin bad++; $display("FAIL rev_resume_model: got %h want %h", act(), exp_v()); end
      end
      total++; if ({bus.len_in, bus.len_dec} !== 8'd96 || bus.busy !== 1'b0) begin
         bad++; $display("FAIL rev_final: got len=%0d busy=%b want len=96 busy=0", {bus.len_in, bus.len_dec}, bus.busy); end
   endtask

   task automatic test_track_and_zero();
      int k;
      drive(1, 200, 0, 100);
      tick_clk();
      total++; if ({bus.len_in, bus.len_dec} !== 8'd200) begin
         bad++; $display("FAIL track_len: got %0d want 200", {bus.len_in, bus.len_dec}); end
      total++; if (act() !== exp_v()) begin bad++; $display("FAIL track_model: got %h want %h", act(), exp_v()); end
      drive(0, 200, 0, 100);
      for (k = 0; k < 300 && m_ph != P_OFF; k++) begin
         tick_clk();
         total++; if (act() !== exp_v()) begin bad++; $display("FAIL track_ret_model: got %h want %h", act(), exp_v()); end
      end
      drive(1, 0, 0, 100);
      repeat (1 + RAMP_DIV) tick_clk();
      total++; if ({bus.saber_on, bus.busy, bus.len_in, bus.len_dec} !== {2'b10, 8'd0}) begin
         bad++; $display("FAIL zero_tgt: got on=%b busy=%b len=%0d want on=1 busy=0 len=0",
                         bus.saber_on, bus.busy, {bus.len_in, bus.len_dec}); end
      drive(0, 0, 0, 100);
      for (k = 0; k < 50 && m_ph != P_OFF; k++) begin
         tick_clk();
         total++; if (act() !== exp_v()) begin bad++; $display("FAIL zero_ret_model: got %h want %h", act(), exp_v()); end
      end
   endtask

   task automatic test_async_reset();
      drive(1, 96, 0, 100);
      for (int i = 0; i < 10; i++) tick_clk();
      total++; if ({bus.len_in, bus.len_dec} !== 8'd16) begin
         bad++; $display("FAIL pre_rst_len: got %0d want 16", {bus.len_in, bus.len_dec}); end
      #2 rst = 1'b1;
      #1;
      total++; if (act() !== 12'h000) begin bad++; $display("FAIL async_rst: got %h want 000", act()); end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 9; i++) begin
         tick_clk();
         total++; if (act() !== exp_v()) begin bad++; $display("FAIL post_rst_model cyc %0d: got %h want %h", i, act(), exp_v()); end
         total++; if ({bus.len_in, bus.len_dec} !== 8'(STEP * (i / RAMP_DIV))) begin
            bad++; $display("FAIL post_rst_len cyc %0d: got %0d want %0d", i, {bus.len_in, bus.len_dec}, STEP * (i / RAMP_DIV)); end
      end
   endtask

   task automatic test_random();
      bit b = 1, w;
      int tgt = 120, lvl = 100;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) b = ~b;
         if ($urandom_range(0, 59) == 0) tgt = $urandom_range(0, 255);
         if ($urandom_range(0, 19) == 0) lvl = $urandom_range(0, 255);
         w = ($urandom_range(0, 149) == 0);
         drive(b, tgt, w, lvl);
         tick_clk();
         total++; if (act() !== exp_v()) begin bad++; $display("FAIL random_model cyc %0d: got %h want %h", i, act(), exp_v()); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_ignite();
      test_retract();
      test_warn_lockout();
      test_reverse();
      test_track_and_zero();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end
endmodule
